// File: rtl/bbox_frame_latch_pkg.sv
// Shared box type and widths for bbox_frame_latch; coordinate widths derive
// from `W_PW/`W_PH (defaulted here for 12-bit picture dimensions).
`ifndef W_PW
`define W_PW 11
`endif
`ifndef W_PH
`define W_PH 11
`endif

package bbox_frame_latch_pkg;

  localparam int unsigned PW_W  = `W_PW + 1;
  localparam int unsigned PH_W  = `W_PH + 1;
  // Signed intermediates: one bit for sign, one for lo + b overflow.
  localparam int unsigned PW_SW = `W_PW + 3;
  localparam int unsigned PH_SW = `W_PH + 3;

  localparam int unsigned DEF_W_SCORE     = 8;
  localparam int unsigned DEF_HOLD_FRAMES = 4;

  typedef struct packed {
    logic [PW_W-1:0] x;
    logic [PH_W-1:0] y;
    logic [PW_W-1:0] w;
    logic [PH_W-1:0] h;
  } box_t;

endpackage

// File: rtl/bbox_frame_latch_axis.sv
// One axis of the box conversion: stage A forms the signed lo/hi span from
// center/size, stage B clips it to [0, pic-1] and flags empty results.
module bbox_axis_clip #(
  parameter int unsigned CW = 12,
  parameter int unsigned SW = 14
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CW-1:0] c,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] pic,
  output logic [CW-1:0] lo_c,
  output logic [CW-1:0] extent,
  output logic          discard
);

  logic signed [SW-1:0] lo_a_q, lo_a_d, hi_a_q, hi_a_d;
  logic                 bz_a_q, bz_a_d;
  logic signed [SW-1:0] lo_cl, hi_cl, pic_m1;
  logic [CW-1:0]        lo_c_q, lo_c_d, ext_q, ext_d;
  logic                 disc_q, disc_d;

  always_comb begin
    lo_a_d = $signed(SW'(c)) - $signed(SW'(b >> 1));
    hi_a_d = lo_a_d + $signed(SW'(b)) - $signed(SW'(1));
    bz_a_d = (b == '0);

    // pic is taken live here, so a resolution change applies to boxes in stage B.
    pic_m1 = $signed(SW'(pic)) - $signed(SW'(1));
    lo_cl  = (lo_a_q < 0) ? '0 : lo_a_q;
    hi_cl  = (hi_a_q > pic_m1) ? pic_m1 : hi_a_q;
    disc_d = bz_a_q || (lo_cl > hi_cl);
    lo_c_d = lo_cl[CW-1:0];
    ext_d  = CW'(hi_cl - lo_cl);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lo_a_q <= '0;
      hi_a_q <= '0;
      bz_a_q <= 1'b0;
      lo_c_q <= '0;
      ext_q  <= '0;
      disc_q <= 1'b0;
    end else begin
      lo_a_q <= lo_a_d;
      hi_a_q <= hi_a_d;
      bz_a_q <= bz_a_d;
      lo_c_q <= lo_c_d;
      ext_q  <= ext_d;
      disc_q <= disc_d;
    end
  end

  assign lo_c    = lo_c_q;
  assign extent  = ext_q;
  assign discard = disc_q;

endmodule

// File: rtl/bbox_frame_latch.sv
// Frame-synchronous detection box latch; boxes are committed only at vsync fall.
// Optional macro BBOX_SCORE_SELECT_EN: keep the highest-scoring box per frame.
module bbox_frame_latch
  import bbox_frame_latch_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int unsigned W_SCORE     = DEF_W_SCORE
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [PW_W-1:0]    pic_width,
  input  logic [PH_W-1:0]    pic_height,
  input  logic               vsync,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PW_W-1:0]    in_cx,
  input  logic [PH_W-1:0]    in_cy,
  input  logic [PW_W-1:0]    in_bw,
  input  logic [PH_W-1:0]    in_bh,
  input  logic [W_SCORE-1:0] in_score,
  output logic [PW_W-1:0]    x,
  output logic [PH_W-1:0]    y,
  output logic [PW_W-1:0]    w,
  output logic [PH_W-1:0]    h,
  output logic               box_valid,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned MISS_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic              in_ready_q, in_ready_d;
  logic              vld_a_q, vld_a_d, vld_b_q, vld_b_d;
  logic              vsync_d1_q, vsync_d1_d, vsync_d2_q, vsync_d2_d;
  logic              commit_q, commit_d;
  box_t              pend_q, pend_d, out_q, out_d, new_box;
  logic              pend_full_q, pend_full_d, box_valid_q, box_valid_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [7:0]        drop_q, drop_d;
  logic [PW_W-1:0]   xlo, xext;
  logic [PH_W-1:0]   ylo, yext;
  logic              xdisc, ydisc, accept, take;

`ifdef BBOX_SCORE_SELECT_EN
  logic [W_SCORE-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic [W_SCORE-1:0] pend_score_q, pend_score_d;
`else
  logic unused_score;
  assign unused_score = ^in_score;
`endif

  assign accept  = in_valid && in_ready_q;
  assign new_box = '{x: xlo, y: ylo, w: xext, h: yext};

  bbox_axis_clip #(.CW(PW_W), .SW(PW_SW)) u_clip_x (
    .clk(clk), .rstn(rstn), .c(in_cx), .b(in_bw), .pic(pic_width),
    .lo_c(xlo), .extent(xext), .discard(xdisc)
  );

  bbox_axis_clip #(.CW(PH_W), .SW(PH_SW)) u_clip_y (
    .clk(clk), .rstn(rstn), .c(in_cy), .b(in_bh), .pic(pic_height),
    .lo_c(ylo), .extent(yext), .discard(ydisc)
  );

  always_comb begin
    in_ready_d  = 1'b1;
    vld_a_d     = accept;
    vld_b_d     = vld_a_q;
    vsync_d1_d  = vsync;
    vsync_d2_d  = vsync_d1_q;
    commit_d    = !vsync_d1_q && vsync_d2_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    out_d       = out_q;
    box_valid_d = box_valid_q;
    miss_d      = miss_q;
    drop_d      = drop_q;
    take        = 1'b0;
`ifdef BBOX_SCORE_SELECT_EN
    score_a_d    = in_score;
    score_b_d    = score_a_q;
    pend_score_d = pend_score_q;
`endif

    // Commit reads the pre-cycle pending; a box arriving now lands in the
    // freshly emptied pending below and belongs to the next frame.
    if (commit_q) begin
      if (pend_full_q) begin
        out_d       = pend_q;
        box_valid_d = 1'b1;
        miss_d      = '0;
      end else begin
        if (miss_q != '1) miss_d = miss_q + MISS_W'(1);
        if ((HOLD_FRAMES != 0) && (32'(miss_d) >= HOLD_FRAMES)) begin
          box_valid_d = 1'b0;
          out_d       = '0;
        end
      end
      pend_full_d = 1'b0;
`ifdef BBOX_SCORE_SELECT_EN
      pend_score_d = '0;
`endif
    end

    if (vld_b_q && (xdisc || ydisc)) begin
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (vld_b_q) begin
`ifdef BBOX_SCORE_SELECT_EN
      take = !pend_full_d || (score_b_q > pend_score_d);
`else
      take = 1'b1;
`endif
      if (take) begin
        pend_d      = new_box;
        pend_full_d = 1'b1;
`ifdef BBOX_SCORE_SELECT_EN
        pend_score_d = score_b_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_ready_q  <= 1'b0;
      vld_a_q     <= 1'b0;
      vld_b_q     <= 1'b0;
      vsync_d1_q  <= 1'b0;
      vsync_d2_q  <= 1'b0;
      commit_q    <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      out_q       <= '0;
      box_valid_q <= 1'b0;
      miss_q      <= '0;
      drop_q      <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      vld_a_q     <= vld_a_d;
      vld_b_q     <= vld_b_d;
      vsync_d1_q  <= vsync_d1_d;
      vsync_d2_q  <= vsync_d2_d;
      commit_q    <= commit_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      out_q       <= out_d;
      box_valid_q <= box_valid_d;
      miss_q      <= miss_d;
      drop_q      <= drop_d;
    end
  end

`ifdef BBOX_SCORE_SELECT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      score_a_q    <= '0;
      score_b_q    <= '0;
      pend_score_q <= '0;
    end else begin
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      pend_score_q <= pend_score_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign x         = out_q.x;
  assign y         = out_q.y;
  assign w         = out_q.w;
  assign h         = out_q.h;
  assign box_valid = box_valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_bbox_frame_latch.sv
// Scoreboard bench for bbox_frame_latch: HOLD_FRAMES=2 and HOLD_FRAMES=0 instances
// share stimulus; a frame-level model queues timed expected output changes.
module tb_bbox_frame_latch;
  import bbox_frame_latch_pkg::*;

  localparam int unsigned W_SC = DEF_W_SCORE;

  typedef struct packed {
    logic            bv;
    logic [PW_W-1:0] x;
    logic [PH_W-1:0] y;
    logic [PW_W-1:0] w;
    logic [PH_W-1:0] h;
  } ostate_t;

  typedef struct {
    int unsigned cyc;
    bit          is_commit;
    ostate_t     s2;
    ostate_t     s0;
  } ev_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [PW_W-1:0] pic_width = PW_W'(1920);
  logic [PH_W-1:0] pic_height = PH_W'(1080);
  logic            vsync = 1'b1;
  logic            in_valid = 1'b0;
  logic [PW_W-1:0] in_cx = '0, in_bw = '0;
  logic [PH_W-1:0] in_cy = '0, in_bh = '0;
  logic [W_SC-1:0] in_score = '0;

  logic            rdy2, rdy0, bv2, bv0;
  logic [PW_W-1:0] x2, w2, x0, w0;
  logic [PH_W-1:0] y2, h2, y0, h0;
  logic [7:0]      drop2, drop0;

  always #5 clk = ~clk;

  bbox_frame_latch #(.HOLD_FRAMES(2), .W_SCORE(W_SC)) dut (
    .clk(clk), .rstn(rstn), .pic_width(pic_width), .pic_height(pic_height),
    .vsync(vsync), .in_valid(in_valid), .in_ready(rdy2), .in_cx(in_cx),
    .in_cy(in_cy), .in_bw(in_bw), .in_bh(in_bh), .in_score(in_score),
    .x(x2), .y(y2), .w(w2), .h(h2), .box_valid(bv2), .drop_cnt(drop2)
  );

  bbox_frame_latch #(.HOLD_FRAMES(0), .W_SCORE(W_SC)) dut_h0 (
    .clk(clk), .rstn(rstn), .pic_width(pic_width), .pic_height(pic_height),
    .vsync(vsync), .in_valid(in_valid), .in_ready(rdy0), .in_cx(in_cx),
    .in_cy(in_cy), .in_bw(in_bw), .in_bh(in_bh), .in_score(in_score),
    .x(x0), .y(y0), .w(w0), .h(h0), .box_valid(bv0), .drop_cnt(drop0)
  );

  int          n_err = 0;
  int          n_chk = 0;
  int unsigned cyc = 0;
  logic        rst_smp = 1'b0;
  ev_t         evq[$];

  // Frame-level reference state owned by the stimulus side.
  bit      fr_full = 0;
  ostate_t fr_box = '0;
  int      fr_score = 0;
  int      miss2 = 0, miss0 = 0;
  ostate_t st2 = '0, st0 = '0;
  bit      prev_vs = 1;

  // Currently visible state owned by the monitor.
  ostate_t cur2 = '0, cur0 = '0;
  int      cur_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic frame_end(input int unsigned hold, inout int miss, inout ostate_t st);
    if (fr_full) begin
      st   = fr_box;
      miss = 0;
    end else begin
      if (miss < 255) miss++;
      if (hold != 0 && miss >= int'(hold)) st = '0;
    end
  endtask

  task automatic model_commit();
    ev_t e;
    frame_end(2, miss2, st2);
    frame_end(0, miss0, st0);
    e.cyc = cyc + 3; e.is_commit = 1; e.s2 = st2; e.s0 = st0;
    evq.push_back(e);
    fr_full = 0;
  endtask

  task automatic model_box(input int cx, input int cy, input int bw, input int bh, input int sc);
    int pw, ph, lx, hx, ly, hy;
    ev_t e;
    pw = int'(pic_width);
    ph = int'(pic_height);
    lx = cx - bw / 2; hx = lx + bw - 1;
    ly = cy - bh / 2; hy = ly + bh - 1;
    if (lx < 0) lx = 0;
    if (ly < 0) ly = 0;
    if (hx > pw - 1) hx = pw - 1;
    if (hy > ph - 1) hy = ph - 1;
    if (bw == 0 || bh == 0 || lx > hx || ly > hy) begin
      e.cyc = cyc + 3; e.is_commit = 0; e.s2 = '0; e.s0 = '0;
      evq.push_back(e);
    end else begin
`ifdef BBOX_SCORE_SELECT_EN
      if (!fr_full || sc > fr_score) begin
`else
      if (1'b1) begin
`endif
        fr_box   = '{bv: 1'b1, x: PW_W'(lx), y: PH_W'(ly), w: PW_W'(hx - lx), h: PH_W'(hy - ly)};
        fr_score = sc;
        fr_full  = 1;
      end
    end
  endtask

  // One input cycle: a vsync fall closes the frame before a same-cycle box is added.
  task automatic step(input logic vs, input logic v, input int cx, input int cy,
                      input int bw, input int bh, input int sc);
    @(posedge clk); #1;
    vsync    = vs;
    in_valid = v;
    in_cx    = PW_W'(cx);
    in_cy    = PH_W'(cy);
    in_bw    = PW_W'(bw);
    in_bh    = PH_W'(bh);
    in_score = W_SC'(sc);
    if (!vs && prev_vs) model_commit();
    if (v) model_box(cx, cy, bw, bh, sc);
    prev_vs = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) step(vsync, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic hi(input int n);
    repeat (n) step(1'b1, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(input int cx, input int cy, input int bw, input int bh, input int sc);
    step(vsync, 1'b1, cx, cy, bw, bh, sc);
  endtask

  // Falls vsync and returns three cycles later, when the commit is visible.
  task automatic commit_frame();
    step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    repeat (3) step(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut(input int n);
    @(posedge clk); #1;
    rstn = 1'b0; in_valid = 1'b0; vsync = 1'b1; prev_vs = 1;
    fr_full = 0; miss2 = 0; miss0 = 0; st2 = '0; st0 = '0;
    repeat (n) begin @(posedge clk); #1; end
    rstn = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rstn;
  end

  always @(negedge clk) begin
    ev_t e;
    if (!rst_smp) begin
      evq.delete();
      cur2 = '0; cur0 = '0; cur_drop = 0;
      chk("in_ready_rst", {rdy2, rdy0}, 0);
      chk("outputs_rst", {bv2, x2, y2, w2, h2, bv0, x0, drop2, drop0}, 0);
    end else begin
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        e = evq.pop_front();
        if (e.is_commit) begin
          cur2 = e.s2;
          cur0 = e.s0;
        end else if (cur_drop < 255) begin
          cur_drop++;
        end
      end
      chk("in_ready", {rdy2, rdy0}, 2'b11);
      chk("hold2_box", 64'({bv2, x2, y2, w2, h2}), 64'(cur2));
      chk("hold0_box", 64'({bv0, x0, y0, w0, h0}), 64'(cur0));
      chk("drop_cnt", {drop2, drop0}, {8'(cur_drop), 8'(cur_drop)});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int pw, ph, cx, cy, bw, bh, sel;
    reset_dut(4);
    hi(3);

    // Basic conversion and exact commit latency.
    send(100, 80, 40, 20, 10);
    idle(2);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    repeat (2) step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    chk("tp1_before_commit", bv2, 0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    chk("tp1_box", {bv2, x2, y2, w2, h2}, {1'b1, 12'd80, 12'd70, 12'd39, 12'd19});
    hi(3);

    // Left clip plus an off-screen box in the same frame.
    send(10, 80, 40, 20, 10);
    send(2000, 80, 10, 20, 10);
    commit_frame();
    chk("left_clip", {bv2, x2, w2, drop2}, {1'b1, 12'd0, 12'd29, 8'd1});
    hi(3);
    send(2000, 80, 10, 20, 10);
    commit_frame();
    chk("offscreen_hold", {bv2, x2, w2, drop2}, {1'b1, 12'd0, 12'd29, 8'd2});
    hi(3);

    // Score ordering.
    send(300, 200, 20, 10, 50);
    send(500, 300, 40, 40, 90);
    commit_frame();
    chk("score_50_90", {x2, y2, w2}, {12'd480, 12'd280, 12'd39});
    hi(3);
    send(500, 300, 40, 40, 90);
    send(300, 200, 20, 10, 50);
    commit_frame();
`ifdef BBOX_SCORE_SELECT_EN
    chk("score_90_50", {x2, y2, w2}, {12'd480, 12'd280, 12'd39});
`else
    chk("score_90_50", {x2, y2, w2}, {12'd290, 12'd195, 12'd19});
`endif
    hi(3);

    // Box reaches stage C in the commit cycle: belongs to the next frame.
    send(700, 400, 10, 10, 10);
    step(1'b0, 1'b1, 900, 500, 10, 10, 10);
    repeat (3) step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    chk("simul_prior", {x2, y2}, {12'd695, 12'd395});
    hi(3);
    commit_frame();
    chk("simul_next", {bv2, x2, y2}, {1'b1, 12'd895, 12'd495});
    hi(3);

    // Expiry after two empty frames for HOLD_FRAMES=2; HOLD_FRAMES=0 holds.
    commit_frame();
    chk("expire_1st_empty", bv2, 1);
    hi(3);
    commit_frame();
    chk("expire_2nd_empty", {bv2, x2, y2, w2, h2}, 0);
    chk("hold0_forever", {bv0, x0}, {1'b1, 12'd895});
    hi(3);

    // Reset with boxes in flight.
    send(400, 400, 20, 20, 10);
    send(2000, 80, 10, 20, 10);
    reset_dut(3);
    hi(3);
    commit_frame();
    chk("after_reset", {bv2, x2, y2, w2, h2, bv0, x0, drop2, drop0}, 0);
    hi(3);

    // Randomized frames across several picture sizes.
    for (int f = 0; f < 45; f++) begin
      if (f % 15 == 0) begin
        hi(3);
        sel = f / 15;
        pic_width  = (sel == 0) ? PW_W'(1920) : (sel == 1) ? PW_W'(640) : PW_W'(64);
        pic_height = (sel == 0) ? PH_W'(1080) : (sel == 1) ? PH_W'(480) : PH_W'(48);
      end
      pw = int'(pic_width);
      ph = int'(pic_height);
      sel = int'($urandom_range(0, 3));
      for (int c = 0; c < int'($urandom_range(10, 34)); c++) begin
        cx = int'($urandom_range(0, pw + 64));
        cy = int'($urandom_range(0, ph + 64));
        bw = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, pw / 2));
        bh = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, ph / 2));
        step((c < 2) ? 1'b1 : 1'b0, (sel != 0) && ($urandom_range(0, 2) == 0),
             cx, cy, bw, bh, int'($urandom_range(0, 255)));
      end
    end
    hi(3);

    // Sustained one-per-cycle discards drive drop_cnt into saturation.
    repeat (260) send(100, 100, 0, 10, 0);
    idle(4);
    chk("drop_saturate", {drop2, drop0}, {8'd255, 8'd255});

    idle(10);
    chk("sb_drain", 64'(evq.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
